fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 8-register pipeline. It owns the PC, drives the synchronous instruction memory, and presents the fetched instruction to decode. It obeys the hazard unit's `PCwrite`/`Id_write` stall controls and the execute stage's branch redirect. It decodes the `Rs`/`Rt` fields that feed back into the hazard detection logic.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the synchronous instruction memory, and parks one fetch in a skid buffer when decode stalls.
module fetch_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCwrite,
  input  logic               Id_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Id_instr,
  output logic [PC_W-1:0]    Id_pc,
  output logic               Id_valid,
  output logic [2:0]         Rs,
  output logic [2:0]         Rt
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               f_valid_q, f_valid_d;
  logic [PC_W-1:0]    f_pc_q, f_pc_d;
  logic               hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic               id_valid_q, id_valid_d;
  logic               issue;

  assign issue      = PCwrite & Id_write & ~branch_taken;
  assign imem_rd_en = ~rst & (issue | branch_taken);
  assign imem_addr  = rst ? RESET_PC : (branch_taken ? branch_target : pc_q);

  assign Id_instr = id_instr_q;
  assign Id_pc    = id_pc_q;
  assign Id_valid = id_valid_q;
  assign Rs       = id_instr_q[8:6];
  assign Rt       = id_instr_q[5:3];

  always_comb begin
    pc_d         = pc_q;
    f_valid_d    = f_valid_q;
    f_pc_d       = f_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;

    if (branch_taken) begin
      // Redirect wins over a stall: flush IF/ID and drop any parked or returning fetch.
      pc_d         = branch_target + PC_ONE;
      f_valid_d    = 1'b1;
      f_pc_d       = branch_target;
      hold_valid_d = 1'b0;
      id_valid_d   = 1'b0;
      id_instr_d   = NOP;
    end else if (!Id_write) begin
      f_valid_d = 1'b0;
      if (f_valid_q) begin
        hold_valid_d = 1'b1;
        hold_instr_d = imem_rdata;
        hold_pc_d    = f_pc_q;
      end
    end else begin
      if (hold_valid_q) begin
        id_valid_d   = 1'b1;
        id_instr_d   = hold_instr_q;
        id_pc_d      = hold_pc_q;
        hold_valid_d = 1'b0;
      end else if (f_valid_q) begin
        id_valid_d = 1'b1;
        id_instr_d = imem_rdata;
        id_pc_d    = f_pc_q;
      end else begin
        id_valid_d = 1'b0;
        id_instr_d = NOP;
      end
      f_valid_d = PCwrite;
      if (PCwrite) begin
        f_pc_d = pc_q;
        pc_d   = pc_q + PC_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      f_valid_q    <= 1'b0;
      f_pc_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc_q    <= '0;
      id_instr_q   <= NOP;
      id_pc_q      <= '0;
      id_valid_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      f_valid_q    <= f_valid_d;
      f_pc_q       <= f_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
    end
  end

endmodule
